// File: rtl/flow_led_pkg.sv
// Shared types for the flow LED controller: FSM states, pattern modes, bounce direction.
package flow_led_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ROT_L  = 2'd0,
        ROT_R  = 2'd1,
        BOUNCE = 2'd2,
        HOLD   = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_L = 1'b0,
        DIR_R = 1'b1
    } dir_t;

endpackage

// File: rtl/flow_led_tick.sv
// Step-interval timer: free counter with a period latched at clear and at every wrap.
module flow_led_tick #(
    parameter int BASE_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       clear,
    input  logic [1:0] speed_sel,
    output logic       wrap
);

    localparam int PER_W = $clog2(BASE_DIV * 8 + 1);

    logic [PER_W-1:0] r_cnt;
    logic [PER_W-1:0] r_period;
    logic [PER_W-1:0] w_period_sel;

    assign w_period_sel = PER_W'(BASE_DIV) << speed_sel;
    assign wrap         = enable && (r_cnt == r_period - PER_W'(1));

    // speed_sel is only sampled here, so a change waits for the next interval
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_period <= PER_W'(BASE_DIV);
        end else if (clear || wrap) begin
            r_cnt    <= '0;
            r_period <= w_period_sel;
        end else if (enable) begin
            r_cnt    <= r_cnt + PER_W'(1);
        end
    end

endmodule

// File: rtl/flow_led_ctrl.sv
// Running-light controller: IDLE/RUN/PAUSE FSM driving a one-hot LED pattern.
module flow_led_ctrl
    import flow_led_pkg::*;
#(
    parameter int LED_NUM  = 4,
    parameter int BASE_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic [1:0]         mode,
    input  logic [1:0]         speed_sel,
    output logic [LED_NUM-1:0] led,
    output logic               step,
    output logic               running
);

    state_t             r_state, w_state_nxt;
    dir_t               r_dir, w_dir_nxt, w_dir_adv;
    logic [LED_NUM-1:0] r_led, w_led_nxt, w_led_adv;
    logic               w_wrap;
    logic               w_enable;
    logic               w_clear;
    mode_t              w_mode;

    assign w_mode   = mode_t'(mode);
    assign w_enable = (r_state == RUN) && !stop;
    assign w_clear  = (r_state == IDLE);

    flow_led_tick #(
        .BASE_DIV(BASE_DIV)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .enable   (w_enable),
        .clear    (w_clear),
        .speed_sel(speed_sel),
        .wrap     (w_wrap)
    );

    always_comb begin
        w_led_adv = r_led;
        w_dir_adv = r_dir;
        case (w_mode)
            ROT_L:  w_led_adv = {r_led[LED_NUM-2:0], r_led[LED_NUM-1]};
            ROT_R:  w_led_adv = {r_led[0], r_led[LED_NUM-1:1]};
            BOUNCE: begin
                // endpoints reverse immediately so each end stays lit one interval
                if (r_dir == DIR_L) begin
                    if (r_led[LED_NUM-1]) begin
                        w_led_adv = r_led >> 1;
                        w_dir_adv = DIR_R;
                    end else begin
                        w_led_adv = r_led << 1;
                    end
                end else begin
                    if (r_led[0]) begin
                        w_led_adv = r_led << 1;
                        w_dir_adv = DIR_L;
                    end else begin
                        w_led_adv = r_led >> 1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_led_nxt   = r_led;
        w_dir_nxt   = r_dir;
        case (r_state)
            IDLE: begin
                w_led_nxt = '0;
                if (start && !stop) begin
                    w_state_nxt = RUN;
                    w_led_nxt   = LED_NUM'(1);
                    w_dir_nxt   = DIR_L;
                end
            end
            RUN: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                    w_led_nxt   = '0;
                end else begin
                    if (w_wrap) begin
                        w_led_nxt = w_led_adv;
                        w_dir_nxt = w_dir_adv;
                    end
                    if (pause) w_state_nxt = PAUSE;
                end
            end
            PAUSE: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                    w_led_nxt   = '0;
                end else if (!pause) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_led_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_led   <= '0;
            r_dir   <= DIR_L;
        end else begin
            r_state <= w_state_nxt;
            r_led   <= w_led_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    assign led     = r_led;
    assign step    = w_wrap;
    assign running = (r_state != IDLE);

endmodule

// File: tb/tb_flow_led_ctrl.sv
// Directed self-checking bench for flow_led_ctrl with LED_NUM=4, BASE_DIV=4.
module tb_flow_led_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [1:0] speed_sel = 2'd0;
    logic [3:0] led;
    logic       step;
    logic       running;

    int n_checks = 0;
    int n_errors = 0;

    flow_led_ctrl #(
        .LED_NUM (4),
        .BASE_DIV(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .mode     (mode),
        .speed_sel(speed_sel),
        .led      (led),
        .step     (step),
        .running  (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_led", 32'(led), 32'h1);
        check("start_run", 32'(running), 32'h1);
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_led", 32'(led), 32'h0);
        check("stop_run", 32'(running), 32'h0);
    endtask

    // Called right after a step edge (counter at 0); walks one full interval.
    task automatic interval(input int p, input logic [3:0] exp_led);
        for (int i = 1; i < p; i++) begin
            tick();
            check("step_pulse", 32'(step), (i == p - 1) ? 32'h1 : 32'h0);
        end
        tick();
        check("led_adv", 32'(led), 32'(exp_led));
    endtask

    initial begin
        logic [3:0] seq_l [4];
        logic [3:0] seq_r [4];
        logic [3:0] seq_b [7];
        seq_l = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        seq_r = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        seq_b = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

        #12;
        check("rst_led", 32'(led), 32'h0);
        check("rst_step", 32'(step), 32'h0);
        check("rst_run", 32'(running), 32'h0);
        rst = 1'b0;
        repeat (3) tick();
        check("idle_led", 32'(led), 32'h0);
        check("idle_run", 32'(running), 32'h0);

        // rotate left
        mode = 2'd0;
        do_start();
        for (int k = 0; k < 4; k++) interval(4, seq_l[k]);
        do_stop();

        // rotate right
        mode = 2'd1;
        do_start();
        for (int k = 0; k < 4; k++) interval(4, seq_r[k]);
        do_stop();

        // bounce
        mode = 2'd2;
        do_start();
        for (int k = 0; k < 7; k++) interval(4, seq_b[k]);
        do_stop();

        // hold keeps pulsing step, then bounce continues leftwards
        mode = 2'd3;
        do_start();
        interval(4, 4'b0001);
        interval(4, 4'b0001);
        mode = 2'd2;
        interval(4, 4'b0010);
        do_stop();

        // speed change mid-interval: current interval stays 4, next is 16
        mode = 2'd0;
        do_start();
        tick();
        tick();
        speed_sel = 2'd2;
        tick();
        check("spd_step", 32'(step), 32'h1);
        tick();
        check("spd_led", 32'(led), 32'b0010);
        interval(16, 4'b0100);
        speed_sel = 2'd0;
        do_stop();

        // pause at count 2 for 10 cycles
        do_start();
        tick();
        tick();
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("pause_step", 32'(step), 32'h0);
            check("pause_led", 32'(led), 32'b0001);
            check("pause_run", 32'(running), 32'h1);
        end
        pause = 1'b0;
        tick();
        check("resume_step", 32'(step), 32'h1);
        tick();
        check("resume_led", 32'(led), 32'b0010);
        interval(4, 4'b0100);
        // stop while showing 0100
        do_stop();

        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_led", 32'(led), 32'h0);
        check("ss_run", 32'(running), 32'h0);
        tick();
        check("ss_led2", 32'(led), 32'h0);
        do_start();

        // start while running is ignored
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("restart_step", 32'(step), 32'h1);
        tick();
        check("restart_led", 32'(led), 32'b0010);

        // asynchronous reset mid-cycle
        tick();
        #3;
        rst = 1'b1;
        #1;
        check("arst_led", 32'(led), 32'h0);
        check("arst_run", 32'(running), 32'h0);
        check("arst_step", 32'(step), 32'h0);
        #1;
        rst = 1'b0;
        repeat (6) begin
            tick();
            check("post_rst_led", 32'(led), 32'h0);
        end
        check("post_rst_run", 32'(running), 32'h0);
        do_start();
        interval(4, 4'b0010);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
